// File: rtl/linear_proj_pkg.sv
// Parameters, types and output scaling shared by the linear-projection matmul wrapper.
// Build option SATURATE_EN: clamp scaled results to the output range instead of wrapping.
package linear_proj_pkg;
  localparam int WIDTH_A           = 16;
  localparam int WIDTH_B           = 16;
  localparam int WIDTH_OUT         = 16;
  localparam int FRAC_WIDTH        = 8;
  localparam int BLOCK_SIZE        = 2;
  localparam int CHUNK_SIZE        = BLOCK_SIZE * BLOCK_SIZE;
  localparam int NUM_CORES_A       = 2;
  localparam int NUM_CORES_B       = 1;
  localparam int TOTAL_MODULES     = 2;
  localparam int INNER_DIMENSION   = 8;
  localparam int A_OUTER_DIMENSION = 8;
  localparam int B_OUTER_DIMENSION = BLOCK_SIZE * NUM_CORES_B * TOTAL_MODULES;

  localparam int K_STEPS       = INNER_DIMENSION / BLOCK_SIZE;
  localparam int TOTAL_INPUT_W = A_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES_A);
  localparam int DEPTH_A       = TOTAL_INPUT_W * K_STEPS;
  localparam int DEPTH_B       = K_STEPS;
  localparam int ADDR_WIDTH_A  = $clog2(DEPTH_A);
  localparam int ADDR_WIDTH_B  = $clog2(DEPTH_B);
  localparam int B_TILES       = NUM_CORES_B * TOTAL_MODULES;
  localparam int NT            = NUM_CORES_A * B_TILES;

  localparam int TILE_A_W = WIDTH_A * CHUNK_SIZE;
  localparam int TILE_B_W = WIDTH_B * CHUNK_SIZE;
  localparam int TILE_O_W = WIDTH_OUT * CHUNK_SIZE;
  localparam int A_WORD_W = TILE_A_W * NUM_CORES_A;
  localparam int B_WORD_W = TILE_B_W * B_TILES;
  localparam int ROW_W    = TILE_O_W * NT;
  localparam int ACC_W    = WIDTH_A + WIDTH_B + $clog2(INNER_DIMENSION);
  localparam int G_W      = (TOTAL_INPUT_W > 1) ? $clog2(TOTAL_INPUT_W) : 1;
  localparam int K_W      = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_STORE, ST_DONE} state_t;

  typedef logic signed [WIDTH_A-1:0]   elem_a_t;
  typedef logic signed [WIDTH_B-1:0]   elem_b_t;
  typedef logic signed [WIDTH_OUT-1:0] elem_out_t;
  typedef logic signed [ACC_W-1:0]     acc_t;
  typedef logic [A_WORD_W-1:0]         a_word_t;
  typedef logic [B_WORD_W-1:0]         b_word_t;
  typedef logic [ROW_W-1:0]            row_t;

  function automatic elem_out_t scale_out(input acc_t acc);
    acc_t sh;
    sh = acc >>> FRAC_WIDTH;
`ifdef SATURATE_EN
    if (sh > acc_t'(2 ** (WIDTH_OUT - 1) - 1))
      return {1'b0, {(WIDTH_OUT - 1){1'b1}}};
    if (sh < -acc_t'(2 ** (WIDTH_OUT - 1)))
      return {1'b1, {(WIDTH_OUT - 1){1'b0}}};
`endif
    return sh[WIDTH_OUT-1:0];
  endfunction
endpackage

// File: rtl/top_mult_wrap_bram_tile_mac.sv
// One BLOCK_SIZE x BLOCK_SIZE tile multiply-accumulate; accumulates one inner step per enabled cycle.
// Result is a combinational scaled view of the accumulators; clr/rst zero them in one cycle.
module tile_mac
  import linear_proj_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [TILE_A_W-1:0] a_tile,
  input  logic [TILE_B_W-1:0] b_tile,
  output logic [TILE_O_W-1:0] res
);
  acc_t acc [CHUNK_SIZE];
  acc_t dot [CHUNK_SIZE];

  always_comb begin
    for (int i = 0; i < CHUNK_SIZE; i++) dot[i] = '0;
    for (int r = 0; r < BLOCK_SIZE; r++)
      for (int c = 0; c < BLOCK_SIZE; c++)
        for (int kk = 0; kk < BLOCK_SIZE; kk++)
          dot[r*BLOCK_SIZE+c] = dot[r*BLOCK_SIZE+c]
            + acc_t'(elem_a_t'(a_tile[(r*BLOCK_SIZE+kk)*WIDTH_A +: WIDTH_A]))
            * acc_t'(elem_b_t'(b_tile[(kk*BLOCK_SIZE+c)*WIDTH_B +: WIDTH_B]));
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < CHUNK_SIZE; i++) acc[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < CHUNK_SIZE; i++) acc[i] <= acc[i] + dot[i];
    end
  end

  always_comb begin
    res = '0;
    for (int i = 0; i < CHUNK_SIZE; i++) res[i*WIDTH_OUT +: WIDTH_OUT] = scale_out(acc[i]);
  end
endmodule

// File: rtl/top_mult_wrap_bram.sv
// Tiled C = A x B over two externally loaded dual-port BRAMs, one registered output row-group per STORE.
// done pulses TOTAL_INPUT_W*(K_STEPS+2)+1 cycles after start; loads and starts are ignored while busy.
module top_mult_wrap_bram
  import linear_proj_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_mat_ena,
  input  logic                    in_mat_wea,
  input  logic                    in_mat_enb,
  input  logic                    in_mat_web,
  input  logic [ADDR_WIDTH_A-1:0] in_mat_wr_addra,
  input  logic [ADDR_WIDTH_A-1:0] in_mat_wr_addrb,
  input  logic [A_WORD_W-1:0]     in_mat_dina,
  input  logic [A_WORD_W-1:0]     in_mat_dinb,
  input  logic                    w_mat_ena,
  input  logic                    w_mat_wea,
  input  logic                    w_mat_enb,
  input  logic                    w_mat_web,
  input  logic [ADDR_WIDTH_B-1:0] w_mat_wr_addra,
  input  logic [ADDR_WIDTH_B-1:0] w_mat_wr_addrb,
  input  logic [B_WORD_W-1:0]     w_mat_dina,
  input  logic [B_WORD_W-1:0]     w_mat_dinb,
  output logic                    done,
  output logic                    out_valid,
  output logic [ROW_W-1:0]        out_multi_matmul [TOTAL_INPUT_W]
);
  a_word_t a_mem [DEPTH_A];
  b_word_t b_mem [DEPTH_B];
  a_word_t a_dout;
  b_word_t b_dout;

  state_t                  state, state_nxt;
  logic [G_W-1:0]          g;
  logic [K_W-1:0]          k;
  logic                    rd_vld;
  logic                    idle, last_k, last_g, acc_clr;
  logic [ADDR_WIDTH_A-1:0] a_rd_addr;
  logic [ADDR_WIDTH_B-1:0] b_rd_addr;
  row_t                    tile_res;

  assign idle      = (state == ST_IDLE);
  assign last_k    = (k == K_W'(K_STEPS - 1));
  assign last_g    = (g == G_W'(TOTAL_INPUT_W - 1));
  assign acc_clr   = (state == ST_STORE);
  assign a_rd_addr = ADDR_WIDTH_A'(g) * ADDR_WIDTH_A'(K_STEPS) + ADDR_WIDTH_A'(k);
  assign b_rd_addr = ADDR_WIDTH_B'(k);

  // Port B is written last so it wins a same-address collision; contents survive rst.
  always_ff @(posedge clk) begin
    if (idle && in_mat_ena && in_mat_wea) a_mem[in_mat_wr_addra] <= in_mat_dina;
    if (idle && in_mat_enb && in_mat_web) a_mem[in_mat_wr_addrb] <= in_mat_dinb;
    if (idle && w_mat_ena && w_mat_wea)   b_mem[w_mat_wr_addra] <= w_mat_dina;
    if (idle && w_mat_enb && w_mat_web)   b_mem[w_mat_wr_addrb] <= w_mat_dinb;
    a_dout <= a_mem[a_rd_addr];
    b_dout <= b_mem[b_rd_addr];
  end

  for (genvar i = 0; i < NUM_CORES_A; i++) begin : g_core_a
    for (genvar j = 0; j < B_TILES; j++) begin : g_core_b
      tile_mac u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .en     (rd_vld),
        .a_tile (a_dout[i*TILE_A_W +: TILE_A_W]),
        .b_tile (b_dout[j*TILE_B_W +: TILE_B_W]),
        .res    (tile_res[(i*B_TILES+j)*TILE_O_W +: TILE_O_W])
      );
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_READ;
      ST_READ:  if (last_k) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_STORE;
      ST_STORE: state_nxt = last_g ? ST_DONE : ST_READ;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // rd_vld trails the READ state by the one-cycle BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      g         <= '0;
      k         <= '0;
      rd_vld    <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < TOTAL_INPUT_W; i++) out_multi_matmul[i] <= '0;
    end else begin
      state  <= state_nxt;
      rd_vld <= (state == ST_READ);
      done   <= (state == ST_DONE);
      if (idle && start)          out_valid <= 1'b0;
      else if (state == ST_DONE)  out_valid <= 1'b1;
      if (state == ST_READ) k <= last_k ? '0 : k + 1'b1;
      if (state == ST_STORE) begin
        out_multi_matmul[g] <= tile_res;
        g <= last_g ? '0 : g + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_top_mult_wrap_bram.sv
// Directed bench for top_mult_wrap_bram with a matrix-level reference model and per-cycle compare.
module tb_top_mult_wrap_bram;
  import linear_proj_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;
  logic in_mat_ena, in_mat_wea, in_mat_enb, in_mat_web;
  logic [ADDR_WIDTH_A-1:0] in_mat_wr_addra, in_mat_wr_addrb;
  logic [A_WORD_W-1:0] in_mat_dina, in_mat_dinb;
  logic w_mat_ena, w_mat_wea, w_mat_enb, w_mat_web;
  logic [ADDR_WIDTH_B-1:0] w_mat_wr_addra, w_mat_wr_addrb;
  logic [B_WORD_W-1:0] w_mat_dina, w_mat_dinb;
  logic done, out_valid;
  logic [ROW_W-1:0] out_multi_matmul [TOTAL_INPUT_W];

  top_mult_wrap_bram dut (
    .clk(clk), .rst(rst), .start(start),
    .in_mat_ena(in_mat_ena), .in_mat_wea(in_mat_wea), .in_mat_enb(in_mat_enb), .in_mat_web(in_mat_web),
    .in_mat_wr_addra(in_mat_wr_addra), .in_mat_wr_addrb(in_mat_wr_addrb),
    .in_mat_dina(in_mat_dina), .in_mat_dinb(in_mat_dinb),
    .w_mat_ena(w_mat_ena), .w_mat_wea(w_mat_wea), .w_mat_enb(w_mat_enb), .w_mat_web(w_mat_web),
    .w_mat_wr_addra(w_mat_wr_addra), .w_mat_wr_addrb(w_mat_wr_addrb),
    .w_mat_dina(w_mat_dina), .w_mat_dinb(w_mat_dinb),
    .done(done), .out_valid(out_valid), .out_multi_matmul(out_multi_matmul)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_edge = -1;
  int last_busy = 0;
  bit chk_en    = 1'b0;
  int ma [8][8];
  int mb [8][4];
  logic [A_WORD_W-1:0] am [8];
  logic [B_WORD_W-1:0] bm [4];
  logic [ROW_W-1:0] pend [2];
  logic [ROW_W-1:0] exp_out [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Matrix element views of the word-packed memory images.
  function automatic int a_elem(input int row, input int kx);
    int w, lane;
    w    = (row / 4) * 4 + kx / 2;
    lane = ((row / 2) % 2) * 4 + (row % 2) * 2 + kx % 2;
    return int'($signed(am[w][lane*16 +: 16]));
  endfunction

  function automatic int b_elem(input int kx, input int col);
    int w, lane;
    w    = kx / 2;
    lane = (col / 2) * 4 + (kx % 2) * 2 + col % 2;
    return int'($signed(bm[w][lane*16 +: 16]));
  endfunction

  function automatic logic [A_WORD_W-1:0] pack_a(input int w);
    logic [A_WORD_W-1:0] v;
    v = '0;
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 2; r++)
        for (int kk = 0; kk < 2; kk++)
          v[(i*4+r*2+kk)*16 +: 16] = 16'(ma[((w/4)*2+i)*2+r][(w%4)*2+kk]);
    return v;
  endfunction

  function automatic logic [B_WORD_W-1:0] pack_b(input int w);
    logic [B_WORD_W-1:0] v;
    v = '0;
    for (int j = 0; j < 2; j++)
      for (int kk = 0; kk < 2; kk++)
        for (int c = 0; c < 2; c++)
          v[(j*4+kk*2+c)*16 +: 16] = 16'(mb[w*2+kk][j*2+c]);
    return v;
  endfunction

  // Plain 8x8 * 8x4 product, scaled by 2^-8, laid out as output row-groups.
  function automatic void model_compute();
    longint s;
    int row, col;
    for (int g = 0; g < 2; g++) begin
      pend[g] = '0;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
              row = (g*2+i)*2+r;
              col = j*2+c;
              s = 0;
              for (int kx = 0; kx < 8; kx++) s += longint'(a_elem(row, kx)) * longint'(b_elem(kx, col));
              s = s >>> 8;
`ifdef SATURATE_EN
              if (s > 32767) s = 32767;
              else if (s < -32768) s = -32768;
`endif
              pend[g][((i*2+j)*4+r*2+c)*16 +: 16] = 16'(s);
            end
    end
  endfunction

  function automatic logic [15:0] lane(input int g, input int l);
    return out_multi_matmul[g][l*16 +: 16];
  endfunction

  always @(negedge clk) begin : cmp
    logic ev;
    if (chk_en) begin
      ev = (done_edge >= 0) && (cyc >= done_edge);
      if (cyc == done_edge) exp_out = pend;
      chk("done", ROW_W'(done), ROW_W'(cyc == done_edge));
      chk("out_valid", ROW_W'(out_valid), ROW_W'(ev));
      if (ev) begin
        chk("row_group0", out_multi_matmul[0], exp_out[0]);
        chk("row_group1", out_multi_matmul[1], exp_out[1]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rst_pulse();
    int e;
    e = cyc + 1;
    rst = 1'b1;
    @(posedge clk);
    done_edge = -1;
    last_busy = e;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start();
    int e;
    e = cyc + 1;
    start = 1'b1;
    @(posedge clk);
    if (e > last_busy) begin
      model_compute();
      done_edge = e + 13;
      last_busy = e + 13;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wr(input bit to_b, input bit pa, input int aa, input logic [A_WORD_W-1:0] da,
                    input bit pb, input int ab, input logic [A_WORD_W-1:0] db);
    int e;
    e = cyc + 1;
    if (to_b) begin
      w_mat_ena = pa; w_mat_wea = pa; w_mat_wr_addra = ADDR_WIDTH_B'(aa); w_mat_dina = da;
      w_mat_enb = pb; w_mat_web = pb; w_mat_wr_addrb = ADDR_WIDTH_B'(ab); w_mat_dinb = db;
    end else begin
      in_mat_ena = pa; in_mat_wea = pa; in_mat_wr_addra = ADDR_WIDTH_A'(aa); in_mat_dina = da;
      in_mat_enb = pb; in_mat_web = pb; in_mat_wr_addrb = ADDR_WIDTH_A'(ab); in_mat_dinb = db;
    end
    @(posedge clk);
    if (e > last_busy) begin
      if (to_b) begin
        if (pa) bm[aa] = da;
        if (pb) bm[ab] = db;
      end else begin
        if (pa) am[aa] = da;
        if (pb) am[ab] = db;
      end
    end
    @(negedge clk);
    in_mat_ena = 0; in_mat_wea = 0; in_mat_enb = 0; in_mat_web = 0;
    w_mat_ena = 0; w_mat_wea = 0; w_mat_enb = 0; w_mat_web = 0;
  endtask

  task automatic load_a();
    for (int w = 0; w < 8; w++) wr(1'b0, 1'b1, w, pack_a(w), 1'b0, 0, '0);
  endtask

  task automatic load_b();
    for (int w = 0; w < 4; w++) wr(1'b1, 1'b0, 0, '0, 1'b1, w, pack_b(w));
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 0; i <= 40; i++) begin
      if (done === 1'b1) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic set_ident_ramp();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) ma[r][c] = (r == c) ? 256 : 0;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 4; c++) mb[r][c] = (r*4 + c + 1) * 256;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0;
    in_mat_ena = 0; in_mat_wea = 0; in_mat_enb = 0; in_mat_web = 0;
    in_mat_wr_addra = '0; in_mat_wr_addrb = '0; in_mat_dina = '0; in_mat_dinb = '0;
    w_mat_ena = 0; w_mat_wea = 0; w_mat_enb = 0; w_mat_web = 0;
    w_mat_wr_addra = '0; w_mat_wr_addrb = '0; w_mat_dina = '0; w_mat_dinb = '0;
    @(negedge clk);
    rst_pulse();
    chk_en = 1'b1;
    chk("reset_done", ROW_W'(done), '0);
    chk("reset_valid", ROW_W'(out_valid), '0);
    chk("reset_out0", out_multi_matmul[0], '0);
    chk("reset_out1", out_multi_matmul[1], '0);

    // Identity A, ramp B: result rows are B rows.
    set_ident_ramp();
    load_a();
    load_b();
    do_start();
    wait_done(n);
    chk_int("latency", n, 13);
    idle(2);
    chk("ident_c00", ROW_W'(lane(0, 0)), ROW_W'(16'h0100));
    chk("ident_c02", ROW_W'(lane(0, 4)), ROW_W'(16'h0300));
    chk("ident_c73", ROW_W'(lane(1, 15)), ROW_W'(16'h2000));

    // Zero A.
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) ma[r][c] = 0;
    load_a();
    do_start();
    idle(16);
    chk("zero_out0", out_multi_matmul[0], '0);
    chk("zero_out1", out_multi_matmul[1], '0);
    chk("zero_valid", ROW_W'(out_valid), ROW_W'(1'b1));

    // Overflow: every element 0x7FFF.
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) ma[r][c] = 32767;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 4; c++) mb[r][c] = 32767;
    load_a();
    load_b();
    do_start();
    idle(16);
`ifdef SATURATE_EN
    chk("ovf_c00", ROW_W'(lane(0, 0)), ROW_W'(16'h7FFF));
    chk("ovf_c73", ROW_W'(lane(1, 15)), ROW_W'(16'h7FFF));
`else
    chk("ovf_c00", ROW_W'(lane(0, 0)), ROW_W'(16'hF800));
    chk("ovf_c73", ROW_W'(lane(1, 15)), ROW_W'(16'hF800));
`endif

    // Second start during READ is ignored.
    set_ident_ramp();
    load_a();
    load_b();
    do_start();
    idle(1);
    do_start();
    wait_done(n);
    chk_int("latency_after_ignored_start", n, 11);
    idle(3);

    // Reset mid-READ, then a clean run.
    do_start();
    idle(1);
    rst_pulse();
    chk("rst_done", ROW_W'(done), '0);
    chk("rst_valid", ROW_W'(out_valid), '0);
    chk("rst_out0", out_multi_matmul[0], '0);
    chk("rst_out1", out_multi_matmul[1], '0);
    do_start();
    wait_done(n);
    chk_int("latency_after_rst", n, 13);
    idle(2);
    chk("rst_rerun_c00", ROW_W'(lane(0, 0)), ROW_W'(16'h0100));

    // Same-address dual-port write (port B wins), then a write while busy.
    wr(1'b1, 1'b1, 0, {8{16'h0500}}, 1'b1, 0, {8{16'h0900}});
    do_start();
    idle(1);
    wr(1'b1, 1'b1, 3, {8{16'h1111}}, 1'b0, 0, '0);
    idle(14);
    chk("dp_c00", ROW_W'(lane(0, 0)), ROW_W'(16'h0900));
    chk("dp_c11", ROW_W'(lane(0, 7)), ROW_W'(16'h0900));
    chk("busy_wr_c73", ROW_W'(lane(1, 15)), ROW_W'(16'h2000));

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
